tx_price: RTL and testbench

TX_PRICE -- requirements
Module: tx_price

---
 rtl/tx_price.sv | 118 +++++++++++
 tb/tb_tx_price.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_price.sv
// Price-frame transmitter: on start, sends "@dddd\r\n" for the selected product
// to a UART TX byte interface using a valid/ready handshake.
module tx_price #(
  parameter int MSG_LEN = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       start,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [3:0] sel, sel_nxt;
  logic [7:0] tx_data_nxt;
  logic       tx_valid_nxt, busy_nxt, done_nxt, err_nxt;

  function automatic logic sel_ok(input logic [3:0] s);
    return (s == 4'd1) || (s == 4'd2) || (s == 4'd4) || (s == 4'd8);
  endfunction

  // Byte at position i of the frame for latched product select s.
  function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [3:0] s);
    logic [31:0] digits;
    case (s)
      4'd1:    digits = "1800";
      4'd2:    digits = "1500";
      4'd4:    digits = "1900";
      4'd8:    digits = "2500";
      default: digits = "XXXX";
    endcase
    case (i)
      3'd0:    return 8'h40;
      3'd1:    return digits[31:24];
      3'd2:    return digits[23:16];
      3'd3:    return digits[15:8];
      3'd4:    return digits[7:0];
      3'd5:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_nxt    = state;
    idx_nxt      = idx;
    sel_nxt      = sel;
    tx_data_nxt  = tx_data;
    tx_valid_nxt = tx_valid;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = SEND;
          idx_nxt      = 3'd0;
          sel_nxt      = din;
          tx_data_nxt  = 8'h40;
          tx_valid_nxt = 1'b1;
          busy_nxt     = 1'b1;
          err_nxt      = !sel_ok(din);
        end
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx == LAST_IDX) begin
            state_nxt    = DONE;
            tx_valid_nxt = 1'b0;
            done_nxt     = 1'b1;
          end else begin
            idx_nxt     = idx + 3'd1;
            tx_data_nxt = frame_byte(idx + 3'd1, sel);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      sel      <= 4'd0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      sel      <= sel_nxt;
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tx_price.sv
// Scoreboard bench for tx_price: stimulus pushes expected frame bytes, a negedge
// monitor pops and compares on every handshake.
module tb_tx_price;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       start;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, busy, done, err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    bit         last;
  } exp_t;

  exp_t exp_q[$];

  tx_price #(.MSG_LEN(7)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .start(start), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: price text per product, whole frame as a byte list.
  function automatic string price_str(input logic [3:0] d);
    case (d)
      4'd1:    return "1800";
      4'd2:    return "1500";
      4'd4:    return "1900";
      4'd8:    return "2500";
      default: return "XXXX";
    endcase
  endfunction

  task automatic push_frame(input logic [3:0] d);
    string s;
    exp_t  e;
    s = price_str(d);
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      e.data = 8'h40;
      else if (i <= 4) e.data = s[i-1];
      else if (i == 5) e.data = 8'h0D;
      else             e.data = 8'h0A;
      e.err  = !(d inside {4'd1, 4'd2, 4'd4, 4'd8});
      e.last = (i == 6);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares transferred bytes, byte stability under backpressure, done pulse.
  int         done_wait = 0;
  bit         hold_valid = 0;
  logic [7:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done_wait == 2) begin
        check("done_pulse", {31'd0, done}, 32'd1);
        done_wait = 1;
      end else if (done_wait == 1) begin
        check("done_clear_busy_low", {30'd0, done, busy}, 32'd0);
        done_wait = 0;
      end
      if (hold_valid && tx_valid) check("hold_stable", {24'd0, tx_data}, {24'd0, held});
      hold_valid = tx_valid && !tx_ready;
      held       = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", {31'd0, tx_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("byte", {24'd0, tx_data}, {24'd0, e.data});
          check("err_level", {31'd0, err}, {31'd0, e.err});
          if (e.last) done_wait = 2;
        end
      end
    end else begin
      hold_valid = 0;
    end
  end

  task automatic start_frame(input logic [3:0] d);
    din   = d;
    start = 1'b1;
    push_frame(d);
    step();
    start = 1'b0;
    check("first_byte", {22'd0, tx_valid, busy, tx_data}, {22'd0, 1'b1, 1'b1, 8'h40});
    check("err_at_start", {31'd0, err}, {31'd0, !(d inside {4'd1, 4'd2, 4'd4, 4'd8})});
  endtask

  // mode 0: ready always, 1: toggle, 2: random. sa/sb: cycles with a stray start.
  task automatic drive_until_idle(input int mode, input bit noise, input int sa, input int sb,
                                  output int cycles);
    bit tog = 1'b1;
    cycles = 0;
    while (busy && cycles < 100) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = tog;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      if (noise) begin
        din   = 4'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        start = (cycles == sa) || (cycles == sb);
      end
      step();
      cycles++;
    end
    start = 1'b0;
    if (cycles >= 100) check("frame_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b1; din = 4'd1; tx_ready = 1'b1;
    repeat (3) step();
    check("reset_state", {20'd0, tx_data, tx_valid, busy, done, err}, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    step();

    // Back-to-back frame, product 1.
    start_frame(4'd1);
    drive_until_idle(0, 0, -1, -1, cyc);
    check("b2b_cycles", cyc, 32'd8);
    step();

    // Product 8 with tx_ready toggling.
    start_frame(4'd8);
    drive_until_idle(1, 0, -1, -1, cyc);
    step();

    // Invalid select, then valid select clears err.
    start_frame(4'd3);
    drive_until_idle(0, 0, -1, -1, cyc);
    check("err_sticky_idle", {31'd0, err}, 32'd1);
    start_frame(4'd2);
    drive_until_idle(0, 0, -1, -1, cyc);

    // Stray starts at idx 3 and in DONE are ignored.
    start_frame(4'd4);
    drive_until_idle(0, 0, 3, 7, cyc);
    step();
    step();
    check("no_queued_frame", {31'd0, busy}, 32'd0);

    // din change mid-frame does not affect the frame.
    start_frame(4'd1);
    din = 4'd8;
    drive_until_idle(2, 0, -1, -1, cyc);

    // Reset at idx 4 aborts the frame.
    start_frame(4'd2);
    tx_ready = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_outputs", {28'd0, tx_valid, busy, done, err}, 32'd0);
    exp_q.delete();
    step();
    start_frame(4'd4);
    drive_until_idle(0, 0, -1, -1, cyc);
    step();

    // Randomized frames with random backpressure and input noise.
    for (int n = 0; n < 30; n++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      start_frame(d);
      drive_until_idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, -1, cyc);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
